data_ram_responder: RTL and testbench
=====================================

Name: data_ram_responder

Overview:
- Data-memory responder at the far end of the MEM-stage memory request interface: ce, we, word address, 4-bit byte select, 32-bit write data.
- Owns a word-organised RAM array. Applies big-endian byte-lane writes, returns read words after a configurable number of wait states, and raises a pipeline stall request while a read is outstanding.
- Sits between the MEM stage and the stall controller; replaces an ideal zero-latency data RAM.

Parameters:
- ADDR_W, 10, word-index width; RAM depth = 2**ADDR_W words.
- WAIT_STATES, 2, extra stalled cycles per read after the acceptance cycle (0..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset: synchronous, active-high.
- ce_i  input  1  request valid (chip enable).
- we_i  input  1  1 = write, 0 = read.
- addr_i  input  32  byte address; bits [1:0] ignored for indexing.
- sel_i  input  4  byte lanes: sel[3] = bits 31:24 (byte offset 0) … sel[0] = bits 7:0 (offset 3).
- wdata_i  input  32  write data, already lane-replicated by requester.
- rdata_o  output  32  read word, registered.
- stall_req_o  output  1  hold-pipeline request.
- err_o  output  1  one-cycle error pulse.

Behaviour:
- Reset values: rdata_o = 0, stall_req_o = 0, err_o = 0, FSM = IDLE, wait counter = 0. RAM contents are not cleared.
- Word index = addr_i[ADDR_W+1:2]. Out-of-range means addr_i[31:ADDR_W+2] != 0.
- FSM states: IDLE, WAIT, DONE.
- IDLE, ce_i=0: no action; stall_req_o = 0.
- IDLE, ce_i=1, we_i=1 (posted write):
  - At this edge, for each k with sel_i[k]=1, RAM[idx] byte k ← wdata_i byte k.
  - stall_req_o stays 0; FSM stays IDLE.
  - sel_i=0000 or out-of-range: no RAM change; err_o=1 in the following cycle.
- IDLE, ce_i=1, we_i=0 (read):
  - stall_req_o = 1 combinationally in this acceptance cycle.
  - Latch index and range flag; load counter = WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, else DONE.
- WAIT: stall_req_o = 1; counter decrements each cycle; at counter==1 → DONE.
- DONE:
  - stall_req_o = 0; rdata_o holds the full word, RAM[latched idx], ignoring sel_i. The requester extracts lanes.
  - Out-of-range read: rdata_o = 0 and err_o = 1 in the DONE cycle.
  - Next state is IDLE unconditionally. ce_i in DONE belongs to the completing request and is never re-accepted.
- Total read stall = WAIT_STATES+1 cycles; data valid in the first unstalled cycle.
- rdata_o holds its value until the next read reaches DONE; writes do not disturb it.
- Requester holds ce/we/addr/sel/wdata stable while stall_req_o=1; the block ignores input changes after acceptance.
- Read-after-write (back-to-back): the write commits at the IDLE edge, so the following read returns the new data.
- rst asserted in WAIT/DONE: abort the read, go to IDLE, stall_req_o=0 next cycle, rdata_o=0. A write accepted in the same cycle as rst is dropped.
- Counter width 4 bits; WAIT_STATES > 15 is illegal and caught by an elaboration check.

Decomposition:
- Shared consts header: ChipEnable/Disable, WriteEnable/Disable, ZeroWord, DataBus/DataAddrBus widths, plus new state encodings DRAM_IDLE/WAIT/DONE.
- One sub-module, byte_lane_ram: 2**ADDR_W × 32 synchronous array with 4 per-byte write enables and a registered read port.
- The FSM, counter and error logic stay in the top module.

Test Plan:
- Reset then IDLE: rst=1 for 2 cycles → rdata_o=0, stall_req_o=0, err_o=0. Read of 0x0000_0010 (RAM initialised to 0xDEAD_BEEF) → stall_req_o=1 for exactly 3 cycles; 4th cycle rdata_o=0xDEADBEEF, stall_req_o=0.
- Byte write: 0x0000_0010 holds 0x1122_3344; SB-style write addr 0x0000_0011, sel 0100, wdata 0xAAAA_AAAA → RAM word = 0x11AA_3344; no stall cycle.
- Halfword + back-to-back read: write addr 0x0000_0012, sel 0011, wdata 0xBEEF_BEEF, then read 0x0000_0010 next cycle → rdata_o = 0x11AA_BEEF after 3 stall cycles.
- Errors:
  - Write with sel 0000 → RAM unchanged, err_o pulses 1 cycle.
  - Read of 0x0000_1000 (ADDR_W=10) → rdata_o=0, err_o=1 in DONE.
- Reset mid-read: assert rst in the 2nd WAIT cycle → stall_req_o=0 the next cycle, rdata_o=0, FSM IDLE. A fresh read then completes normally.
- WAIT_STATES=0 build: read accepted → exactly 1 stall cycle; ce_i held high in DONE does not launch a second read.

Source files
------------

// File: rtl/data_ram_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_ram_responder_pkg
// Shared constants for the data-memory responder: request-interface
// encodings, bus widths and the responder FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package data_ram_responder_pkg;

    localparam logic ChipEnable    = 1'b1;
    localparam logic ChipDisable   = 1'b0;
    localparam logic WriteEnable   = 1'b1;
    localparam logic WriteDisable  = 1'b0;

    localparam int   DataBusW      = 32;
    localparam int   DataAddrBusW  = 32;

    localparam logic [DataBusW-1:0] ZeroWord = '0;

    typedef enum logic [1:0] {
        DRAM_IDLE = 2'd0,
        DRAM_WAIT = 2'd1,
        DRAM_DONE = 2'd2
    } dram_state_e;

endpackage

// File: rtl/data_ram_responder_byte_lane_ram.sv
// -----------------------------------------------------------------------------
// data_ram_responder_byte_lane_ram
// 2**ADDR_W x 32-bit word array with one write enable per byte lane and a
// registered read port. The read register only updates when i_re is high, so
// it holds the last read word between reads; i_clr forces it to zero
// (used for reset and for out-of-range reads).
//
// Ports:
//   clk      in   clock, rising edge
//   i_we     in   4   per-lane write enables, i_we[k] -> bits 8k+7:8k
//   i_waddr  in   ADDR_W  write word index
//   i_wdata  in   32  write data
//   i_re     in   1   load the read register from i_raddr
//   i_clr    in   1   synchronous clear of the read register (wins over i_re)
//   i_raddr  in   ADDR_W  read word index
//   o_rdata  out  32  registered read word
// -----------------------------------------------------------------------------
module data_ram_responder_byte_lane_ram
    import data_ram_responder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic [3:0]          i_we,
    input  logic [ADDR_W-1:0]   i_waddr,
    input  logic [DataBusW-1:0] i_wdata,
    input  logic                i_re,
    input  logic                i_clr,
    input  logic [ADDR_W-1:0]   i_raddr,
    output logic [DataBusW-1:0] o_rdata
);

    localparam int Depth = 2 ** ADDR_W;

    logic [DataBusW-1:0] r_mem [Depth];
    logic [DataBusW-1:0] r_q;

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (i_we[k]) begin
                r_mem[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_q <= ZeroWord;
        end else if (i_re) begin
            r_q <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/data_ram_responder.sv
// -----------------------------------------------------------------------------
// data_ram_responder
// Data-memory responder at the far end of the MEM-stage request interface.
// Writes are posted (committed at the accepting edge, no stall). Reads stall
// the pipeline for WAIT_STATES+1 cycles and deliver the full word in the
// first unstalled cycle (DONE). Bad requests (empty byte select on a write,
// or an address beyond the array) raise a one-cycle err_o pulse.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous, active-high reset
//   ce_i         in   request valid
//   we_i         in   1 = write, 0 = read
//   addr_i       in   32  byte address, bits [1:0] ignored
//   sel_i        in   4   byte lanes, sel_i[3] = bits 31:24 (offset 0)
//   wdata_i      in   32  lane-replicated write data
//   rdata_o      out  32  registered read word
//   stall_req_o  out  1   hold-pipeline request
//   err_o        out  1   one-cycle error pulse
// -----------------------------------------------------------------------------
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce_i,
    input  logic                    we_i,
    input  logic [DataAddrBusW-1:0] addr_i,
    input  logic [3:0]              sel_i,
    input  logic [DataBusW-1:0]     wdata_i,
    output logic [DataBusW-1:0]     rdata_o,
    output logic                    stall_req_o,
    output logic                    err_o
);

    generate
        if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
            $error("data_ram_responder: WAIT_STATES must be in 0..15");
        end
        if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr_w
            $error("data_ram_responder: ADDR_W must be in 1..29");
        end
    endgenerate

    localparam logic [3:0] WsCount = WAIT_STATES[3:0];
    localparam logic       NoWait  = (WAIT_STATES == 0);

    dram_state_e         r_state;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_idx;
    logic                r_oor;
    logic                r_err;

    logic [ADDR_W-1:0]   w_idx;
    logic                w_oor;
    logic                w_accept;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic [3:0]          w_byte_we;
    logic                w_rd_issue;
    logic [ADDR_W-1:0]   w_raddr;
    logic                w_rd_oor;
    logic                w_ram_clr;
    logic [DataBusW-1:0] w_ram_q;
    logic                w_unused_addr;

    // Byte offset bits are not part of the word index.
    assign w_unused_addr = &{1'b0, addr_i[1:0]};

    assign w_idx    = addr_i[ADDR_W+1:2];
    assign w_oor    = |addr_i[DataAddrBusW-1:ADDR_W+2];

    assign w_accept = (r_state == DRAM_IDLE) && (ce_i == ChipEnable);
    assign w_wr_acc = w_accept && (we_i == WriteEnable);
    assign w_rd_acc = w_accept && (we_i == WriteDisable);

    // A write coinciding with rst is dropped, as is an out-of-range write.
    assign w_byte_we = (w_wr_acc && !w_oor && !rst) ? sel_i : 4'b0000;

    // The RAM read register is loaded on the edge that enters DONE, so the
    // word is present during the DONE cycle. With no wait states that edge is
    // the accepting one and the index comes straight from the request.
    assign w_rd_issue = (w_rd_acc && NoWait) ||
                        ((r_state == DRAM_WAIT) && (r_cnt == 4'd1));
    assign w_raddr    = (r_state == DRAM_IDLE) ? w_idx : r_idx;
    assign w_rd_oor   = (r_state == DRAM_IDLE) ? w_oor : r_oor;
    assign w_ram_clr  = rst || (w_rd_issue && w_rd_oor);

    data_ram_responder_byte_lane_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_byte_we),
        .i_waddr (w_idx),
        .i_wdata (wdata_i),
        .i_re    (w_rd_issue),
        .i_clr   (w_ram_clr),
        .i_raddr (w_raddr),
        .o_rdata (w_ram_q)
    );

    // Stall is raised combinationally in the accepting cycle so the pipeline
    // never advances past an outstanding read.
    assign stall_req_o = w_rd_acc || (r_state == DRAM_WAIT);
    assign rdata_o     = w_ram_q;
    assign err_o       = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DRAM_IDLE;
            r_cnt   <= 4'd0;
            r_oor   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                DRAM_IDLE: begin
                    if (w_wr_acc) begin
                        r_err <= (sel_i == 4'b0000) || w_oor;
                    end else if (w_rd_acc) begin
                        r_idx <= w_idx;
                        r_oor <= w_oor;
                        r_cnt <= WsCount;
                        if (NoWait) begin
                            r_state <= DRAM_DONE;
                            r_err   <= w_oor;
                        end else begin
                            r_state <= DRAM_WAIT;
                        end
                    end
                end
                DRAM_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= DRAM_DONE;
                        r_err   <= r_oor;
                    end
                end
                DRAM_DONE: begin
                    // ce_i here still belongs to the completing request.
                    r_state <= DRAM_IDLE;
                end
                default: begin
                    r_state <= DRAM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_ram_responder.sv
module tb_data_ram_responder;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        err;
    logic [31:0] rdata0;
    logic        stall0;
    logic        err0;

    int checks;
    int errors;

    data_ram_responder #(.ADDR_W(10), .WAIT_STATES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .ce_i        (ce),
        .we_i        (we),
        .addr_i      (addr),
        .sel_i       (sel),
        .wdata_i     (wdata),
        .rdata_o     (rdata),
        .stall_req_o (stall),
        .err_o       (err)
    );

    data_ram_responder #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .ce_i        (ce),
        .we_i        (we),
        .addr_i      (addr),
        .sel_i       (sel),
        .wdata_i     (wdata),
        .rdata_o     (rdata0),
        .stall_req_o (stall0),
        .err_o       (err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step();
        ce = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, output logic st);
        step();
        ce = 1'b1; we = 1'b1; addr = a; sel = s; wdata = d;
        @(negedge clk);
        st = stall;
    endtask

    // Issues a read on the WAIT_STATES=2 instance, counts stalled cycles
    // (bounded) and captures rdata/err in the first unstalled cycle.
    task automatic run_read(input logic [31:0] a, input logic hold_ce,
                            output int nstall, output logic [31:0] rd,
                            output logic er);
        step();
        ce = 1'b1; we = 1'b0; addr = a; sel = 4'b1111;
        nstall = 0;
        rd = 32'hxxxx_xxxx;
        er = 1'bx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!stall) begin
                rd = rdata;
                er = err;
                break;
            end
            nstall++;
            step();
        end
        if (!hold_ce) ce = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ce = 1'b0; we = 1'b0; addr = '0; sel = '0; wdata = '0;
        step();
        step();
        @(negedge clk);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected %h", rdata, 32'h0); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected %b", stall, 1'b0); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected %b", err, 1'b0); end
        checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_rdata_ws0: got %h expected %h", rdata0, 32'h0); end
        checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL reset_stall_ws0: got %b expected %b", stall0, 1'b0); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_basic_read();
        logic st;
        int n;
        logic [31:0] rd;
        logic er;
        wr(32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, st);
        checks++; if (st !== 1'b0) begin errors++; $display("FAIL write_no_stall: got %b expected %b", st, 1'b0); end
        idle();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL write_no_err: got %b expected %b", err, 1'b0); end
        run_read(32'h0000_0010, 1'b0, n, rd, er);
        checks++; if (n !== 3) begin errors++; $display("FAIL read_stall_cycles: got %0d expected %0d", n, 3); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_data: got %h expected %h", rd, 32'hDEAD_BEEF); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL read_err: got %b expected %b", er, 1'b0); end
    endtask

    task automatic test_byte_write();
        logic st;
        int n;
        logic [31:0] rd;
        logic er;
        wr(32'h0000_0010, 4'b1111, 32'h1122_3344, st);
        wr(32'h0000_0011, 4'b0100, 32'hAAAA_AAAA, st);
        checks++; if (st !== 1'b0) begin errors++; $display("FAIL byte_write_stall: got %b expected %b", st, 1'b0); end
        idle();
        run_read(32'h0000_0010, 1'b0, n, rd, er);
        checks++; if (rd !== 32'h11AA_3344) begin errors++; $display("FAIL byte_write_data: got %h expected %h", rd, 32'h11AA_3344); end
    endtask

    task automatic test_back_to_back();
        logic st;
        int n;
        logic [31:0] rd;
        logic er;
        wr(32'h0000_0012, 4'b0011, 32'hBEEF_BEEF, st);
        run_read(32'h0000_0010, 1'b0, n, rd, er);
        checks++; if (n !== 3) begin errors++; $display("FAIL b2b_stall_cycles: got %0d expected %0d", n, 3); end
        checks++; if (rd !== 32'h11AA_BEEF) begin errors++; $display("FAIL b2b_data: got %h expected %h", rd, 32'h11AA_BEEF); end
        // A later write must not disturb the held read word.
        wr(32'h0000_0010, 4'b1111, 32'h0000_0000, st);
        idle();
        checks++; if (rdata !== 32'h11AA_BEEF) begin errors++; $display("FAIL rdata_hold: got %h expected %h", rdata, 32'h11AA_BEEF); end
    endtask

    task automatic test_errors();
        logic st;
        int n;
        logic [31:0] rd;
        logic er;
        wr(32'h0000_0020, 4'b1111, 32'h5566_7788, st);
        wr(32'h0000_0020, 4'b0000, 32'hFFFF_FFFF, st);
        idle();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL sel0_err: got %b expected %b", err, 1'b1); end
        idle();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL sel0_err_pulse: got %b expected %b", err, 1'b0); end
        run_read(32'h0000_0020, 1'b0, n, rd, er);
        checks++; if (rd !== 32'h5566_7788) begin errors++; $display("FAIL sel0_ram_unchanged: got %h expected %h", rd, 32'h5566_7788); end

        wr(32'h0000_0000, 4'b1111, 32'h0102_0304, st);
        wr(32'h0000_1000, 4'b1111, 32'hFFFF_FFFF, st);
        idle();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_write_err: got %b expected %b", err, 1'b1); end
        run_read(32'h0000_0000, 1'b0, n, rd, er);
        checks++; if (rd !== 32'h0102_0304) begin errors++; $display("FAIL oor_write_dropped: got %h expected %h", rd, 32'h0102_0304); end

        run_read(32'h0000_1000, 1'b0, n, rd, er);
        checks++; if (n !== 3) begin errors++; $display("FAIL oor_read_stall: got %0d expected %0d", n, 3); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_read_data: got %h expected %h", rd, 32'h0); end
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_read_err: got %b expected %b", er, 1'b1); end
        idle();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL oor_read_err_pulse: got %b expected %b", err, 1'b0); end
    endtask

    task automatic test_reset_mid_read();
        int n;
        logic [31:0] rd;
        logic er;
        run_read(32'h0000_0020, 1'b0, n, rd, er);
        checks++; if (rd !== 32'h5566_7788) begin errors++; $display("FAIL pre_abort_data: got %h expected %h", rd, 32'h5566_7788); end
        step();
        ce = 1'b1; we = 1'b0; addr = 32'h0000_0020; sel = 4'b1111;
        step();            // first WAIT cycle
        step();            // second WAIT cycle
        rst = 1'b1;
        @(negedge clk);
        step();
        rst = 1'b0;
        ce = 1'b0;
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL abort_stall: got %b expected %b", stall, 1'b0); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL abort_rdata: got %h expected %h", rdata, 32'h0); end
        run_read(32'h0000_0020, 1'b0, n, rd, er);
        checks++; if (n !== 3) begin errors++; $display("FAIL post_abort_stall: got %0d expected %0d", n, 3); end
        checks++; if (rd !== 32'h5566_7788) begin errors++; $display("FAIL post_abort_data: got %h expected %h", rd, 32'h5566_7788); end

        // A write presented together with rst is dropped.
        step();
        rst = 1'b1;
        ce = 1'b1; we = 1'b1; addr = 32'h0000_0020; sel = 4'b1111; wdata = 32'hFFFF_FFFF;
        step();
        rst = 1'b0;
        ce = 1'b0;
        run_read(32'h0000_0020, 1'b0, n, rd, er);
        checks++; if (rd !== 32'h5566_7788) begin errors++; $display("FAIL rst_write_dropped: got %h expected %h", rd, 32'h5566_7788); end
    endtask

    task automatic test_ws0();
        logic st;
        wr(32'h0000_0030, 4'b1111, 32'hCAFE_F00D, st);
        wr(32'h0000_0034, 4'b1111, 32'h1234_5678, st);
        idle();
        step();
        ce = 1'b1; we = 1'b0; addr = 32'h0000_0030; sel = 4'b1111;
        @(negedge clk);
        checks++; if (stall0 !== 1'b1) begin errors++; $display("FAIL ws0_accept_stall: got %b expected %b", stall0, 1'b1); end
        step();
        // DONE cycle: ce stays high and the address changes; neither may start a new read.
        addr = 32'h0000_0034;
        @(negedge clk);
        checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL ws0_done_stall: got %b expected %b", stall0, 1'b0); end
        checks++; if (rdata0 !== 32'hCAFE_F00D) begin errors++; $display("FAIL ws0_done_data: got %h expected %h", rdata0, 32'hCAFE_F00D); end
        step();
        ce = 1'b0;
        @(negedge clk);
        checks++; if (stall0 !== 1'b0) begin errors++; $display("FAIL ws0_after_stall: got %b expected %b", stall0, 1'b0); end
        checks++; if (rdata0 !== 32'hCAFE_F00D) begin errors++; $display("FAIL ws0_no_reaccept: got %h expected %h", rdata0, 32'hCAFE_F00D); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        ce = 1'b0; we = 1'b0; addr = '0; sel = '0; wdata = '0;
        test_reset();
        test_basic_read();
        test_byte_write();
        test_back_to_back();
        test_errors();
        test_reset_mid_read();
        test_ws0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
